// File: rtl/noc_arbiter_lock_rr_if.sv
// Request/grant bundle between N input channels and one output-port arbiter.
interface noc_arbiter_lock_rr_if #(
  parameter int N   = 5,
  parameter int IDW = 3
);
  logic [N-1:0]   req;
  logic [N-1:0]   rel;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  modport master (output req, rel, input gnt, gnt_valid, gnt_id);
  modport slave  (input req, rel, output gnt, gnt_valid, gnt_id);
endinterface

// File: rtl/noc_arbiter_lock_rr.sv
// Locking output-port arbiter: grant held for a whole packet, released by tail,
// dropped request or hold timeout, and handed to the next winner without a bubble.
module noc_arbiter_lock_rr_lane (
  input  logic req,
  input  logic own,
  input  logic excl,
  output logic cand
);
  // A channel that just released by tail/timeout sits out this round.
  assign cand = req & ~(own & excl);
endmodule

module noc_arbiter_lock_rr #(
  parameter int N        = 5,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8,
  parameter int IDW      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_arbiter_lock_rr_if.slave  bus
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDW-1:0]    ID_LAST   = IDW'(N - 1);

  logic [N-1:0]      gnt_q;
  logic              vld_q;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    ptr_q;
  logic [HOLD_W-1:0] hold_q;

  logic [N-1:0]   req_v, cand, pick;
  logic           own_req, own_rel, timeout, keep, excl;
  logic           win_ok;
  logic [IDW-1:0] win_id, nxt_ptr;

  assign req_v   = bus.req;
  assign own_req = bus.req[id_q];
  assign own_rel = bus.rel[id_q];
  assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign keep    = vld_q & own_req & ~own_rel & ~timeout;
  assign excl    = vld_q & (own_rel | timeout);

  for (genvar i = 0; i < N; i++) begin : g_lane
    noc_arbiter_lock_rr_lane u_lane (
      .req  (req_v[i]),
      .own  (gnt_q[i]),
      .excl (excl),
      .cand (cand[i])
    );
  end

  // Empty candidate set falls back to the raw requests, re-granting the owner.
  assign pick = (|cand) ? cand : req_v;

  always_comb begin
    win_ok = 1'b0;
    win_id = '0;
    for (int j = 0; j < N; j++) begin
      if (!win_ok && pick[(MODE != 0) ? ((int'(ptr_q) + j) % N) : j]) begin
        win_ok = 1'b1;
        win_id = IDW'((MODE != 0) ? ((int'(ptr_q) + j) % N) : j);
      end
    end
  end

  assign nxt_ptr = (win_id == ID_LAST) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      vld_q  <= 1'b0;
      id_q   <= '0;
      ptr_q  <= '0;
      hold_q <= '0;
    end else if (keep) begin
      hold_q <= (hold_q == '1) ? hold_q : hold_q + 1'b1;
    end else if (win_ok) begin
      gnt_q  <= {{(N-1){1'b0}}, 1'b1} << win_id;
      vld_q  <= 1'b1;
      id_q   <= win_id;
      ptr_q  <= nxt_ptr;
      hold_q <= '0;
    end else begin
      gnt_q  <= '0;
      vld_q  <= 1'b0;
      id_q   <= '0;
      hold_q <= '0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;
  assign bus.gnt_id    = id_q;
endmodule

// File: tb/tb_noc_arbiter_lock_rr.sv
// Four arbiter configurations driven side by side and checked every cycle
// against an integer-level reference model, plus directed scenario checks.
module tb_noc_arbiter_lock_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] rq [4];
  logic [4:0] rl [4];
  logic [4:0] og [4];
  logic       ov [4];
  logic [2:0] oi [4];

  // d0: fixed prio; d1: rr; d2: rr + MAX_HOLD=4; d3: N=2 rr
  int cn  [4] = '{5, 5, 5, 2};
  int cm  [4] = '{0, 1, 1, 1};
  int cmh [4] = '{0, 0, 4, 0};
  int m_own [4];
  int m_ptr [4];
  int m_hold[4];

  noc_arbiter_lock_rr_if #(.N(5), .IDW(3)) ifa ();
  noc_arbiter_lock_rr_if #(.N(5), .IDW(3)) ifb ();
  noc_arbiter_lock_rr_if #(.N(5), .IDW(3)) ifc ();
  noc_arbiter_lock_rr_if #(.N(2), .IDW(1)) ifd ();

  assign ifa.req = rq[0]; assign ifa.rel = rl[0];
  assign ifb.req = rq[1]; assign ifb.rel = rl[1];
  assign ifc.req = rq[2]; assign ifc.rel = rl[2];
  assign ifd.req = rq[3][1:0]; assign ifd.rel = rl[3][1:0];
  assign og[0] = ifa.gnt; assign ov[0] = ifa.gnt_valid; assign oi[0] = ifa.gnt_id;
  assign og[1] = ifb.gnt; assign ov[1] = ifb.gnt_valid; assign oi[1] = ifb.gnt_id;
  assign og[2] = ifc.gnt; assign ov[2] = ifc.gnt_valid; assign oi[2] = ifc.gnt_id;
  assign og[3] = {3'b0, ifd.gnt}; assign ov[3] = ifd.gnt_valid; assign oi[3] = {2'b0, ifd.gnt_id};

  noc_arbiter_lock_rr #(.N(5), .MODE(0), .MAX_HOLD(0), .HOLD_W(8), .IDW(3))
    d0 (.clk(clk), .rst(rst), .bus(ifa));
  noc_arbiter_lock_rr #(.N(5), .MODE(1), .MAX_HOLD(0), .HOLD_W(8), .IDW(3))
    d1 (.clk(clk), .rst(rst), .bus(ifb));
  noc_arbiter_lock_rr #(.N(5), .MODE(1), .MAX_HOLD(4), .HOLD_W(8), .IDW(3))
    d2 (.clk(clk), .rst(rst), .bus(ifc));
  noc_arbiter_lock_rr #(.N(2), .MODE(1), .MAX_HOLD(0), .HOLD_W(8), .IDW(1))
    d3 (.clk(clk), .rst(rst), .bus(ifd));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 4; k++) begin
      m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0;
    end
  endtask

  // Reference: owner kept unless release; otherwise search the request list
  // (skipping a tail/timeout owner first) in priority or rotating order.
  task automatic mstep(input int k);
    int n, own, excl, w;
    logic [4:0] r, l;
    bit to;
    n = cn[k]; own = m_own[k]; r = rq[k]; l = rl[k]; excl = -1; w = -1;
    if (own >= 0) begin
      to = (cmh[k] != 0) && (m_hold[k] == cmh[k] - 1);
      if (r[own] && !l[own] && !to) begin
        if (m_hold[k] < 255) m_hold[k]++;
        return;
      end
      if (l[own] || to) excl = own;
    end
    for (int pass = 0; pass < 2; pass++)
      for (int j = 0; j < n; j++) begin
        int i;
        i = (cm[k] != 0) ? (m_ptr[k] + j) % n : j;
        if (w < 0 && r[i] && (pass == 1 || i != excl)) w = i;
      end
    if (w >= 0) begin
      m_own[k] = w; m_ptr[k] = (w + 1) % n; m_hold[k] = 0;
    end else begin
      m_own[k] = -1; m_hold[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d.gnt", k), og[k], (m_own[k] >= 0) ? (32'd1 << m_own[k]) : 32'd0);
      chk($sformatf("d%0d.gnt_valid", k), ov[k], (m_own[k] >= 0) ? 1 : 0);
      chk($sformatf("d%0d.gnt_id", k), oi[k], (m_own[k] >= 0) ? m_own[k] : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) mstep(k);
    #1;
    check_all();
  endtask

  task automatic idle();
    for (int k = 0; k < 4; k++) begin rq[k] = '0; rl[k] = '0; end
  endtask

  int exp3 [8] = '{2, 2, 2, 2, 3, 3, 3, 3};

  initial begin
    idle();
    mreset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // 1: fixed priority, drop owner's req -> next owner with no gap, then idle
    rq[0] = 5'b10110;
    tick(); chk("t1.first", og[0], 5'b00010);
    tick(); tick(); tick();
    chk("t1.held", og[0], 5'b00010);
    rq[0] = 5'b10100;
    tick(); chk("t1.handoff", og[0], 5'b00100);
    rq[0] = 5'b00000;
    tick(); chk("t1.empty_gnt", og[0], 5'b0); chk("t1.empty_vld", ov[0], 1'b0);

    // 2: rr with tail every third cycle of each grant
    rq[1] = 5'b11111;
    tick();
    for (int g = 0; g < 6; g++) begin
      chk("t2.id", oi[1], g % 5);
      if (g == 5) break;
      tick(); chk("t2.id_c2", oi[1], g % 5);
      tick(); chk("t2.id_c3", oi[1], g % 5);
      rl[1] = 5'b1 << (g % 5);
      tick();
      rl[1] = '0;
    end

    // 3: hold timeout alternates two requesters, single requester is re-granted
    rq[2] = 5'b01100;
    for (int c = 0; c < 8; c++) begin
      tick(); chk("t3.alt", og[2], 5'b1 << exp3[c]);
    end
    tick(); chk("t3.back", og[2], 5'b00100);
    rq[2] = 5'b00100;
    for (int c = 0; c < 10; c++) begin
      tick(); chk("t3.solo", og[2], 5'b00100);
    end
    idle();

    // 4: foreign rel and new lower-index req ignored while locked
    rq[0] = 5'b00010;
    tick(); chk("t4.lock", og[0], 5'b00010);
    rq[0] = 5'b00011; rl[0] = 5'b01000;
    tick(); chk("t4.ignore", og[0], 5'b00010);
    rq[0] = 5'b00001; rl[0] = 5'b00010;
    tick(); chk("t4.pass", og[0], 5'b00001);
    idle();
    tick();

    // 5: async reset mid-cycle clears a locked owner and the rr pointer
    rq[1] = 5'b10000;
    tick(); chk("t5.own4", og[1], 5'b10000);
    tick();
    rst = 1'b1;
    #2;
    mreset();
    check_all();
    rst = 1'b0;
    rq[1] = 5'b11111;
    tick(); chk("t5.ptr0", og[1], 5'b00001);
    idle();
    tick();

    // 6: N=2 with rel every cycle alternates without a bubble
    rq[3] = 5'b00011;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk("t6.gnt", og[3], (c % 2 == 0) ? 5'b01 : 5'b10);
      chk("t6.vld", ov[3], 1'b1);
      rl[3] = og[3];
      tick();
    end
    idle();
    tick();

    // random traffic on all four configurations
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) rq[k] = 5'($urandom);
        rl[k] = 5'($urandom & $urandom & $urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
